// File: rtl/gray_pkg.sv
// gray_pkg: Gray/binary conversion helpers for the up/down counter and for
// async-FIFO pointer logic.
// The functions operate on a fixed maximum-width word. Callers zero-extend
// their N-bit value into it and truncate the result back to N bits. Zero
// upper bits convert to zero in both directions, so the N-bit result is exact.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gword_t;

    // b ^ (b >> 1)
    function automatic gword_t bin2gray(input gword_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR starting at the MSB: bin[i] = bin[i+1] ^ gray[i]
    function automatic gword_t gray2bin(input gword_t g);
        gword_t b;
        b = '0;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_updown_counter.sv
// gray_updown_counter: N-bit up/down counter with registered Gray and binary
// outputs. count_gray comes directly from a flop, so it is glitch-free and
// can feed a 2-flop synchroniser.
// Ports:
//   clk        rising-edge clock
//   srst       synchronous active-high reset (highest priority)
//   en         step enable, one step per cycle
//   up_dn      1 = up, 0 = down (only used when en=1)
//   load       parallel load strobe (beats en)
//   load_gray  Gray-coded load value
//   count_gray registered Gray count, always bin2gray(count_bin)
//   count_bin  registered binary count
//   wrap       one-cycle pulse after a modulo wrap step
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int          N        = 4,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_gray,
    output logic [N-1:0] count_gray,
    output logic [N-1:0] count_bin,
    output logic         wrap
);

    localparam logic [N-1:0] RST_BIN  = N'(RST_VAL);
    localparam logic [N-1:0] RST_GRAY = N'(bin2gray(GRAY_MAX_W'(RST_BIN)));

    logic [N-1:0] bin_nxt;
    logic [N-1:0] gray_nxt;
    logic         wrap_nxt;
    logic         at_end;

    always_comb begin
        bin_nxt  = count_bin;
        wrap_nxt = 1'b0;
        // Sitting at the terminal value for the requested direction
        at_end   = up_dn ? (count_bin == {N{1'b1}}) : (count_bin == '0);

        if (load) begin
            bin_nxt = N'(gray2bin(GRAY_MAX_W'(load_gray)));
        end else if (en) begin
            // In saturate mode a step past the terminal value is dropped
            if (!(at_end && SATURATE)) begin
                bin_nxt  = up_dn ? count_bin + N'(1) : count_bin - N'(1);
                wrap_nxt = at_end;
            end
        end

        // Gray is derived from the next binary value and then registered, so
        // no input reaches count_gray combinationally. For a load, this
        // reproduces load_gray exactly.
        gray_nxt = N'(bin2gray(GRAY_MAX_W'(bin_nxt)));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_bin  <= RST_BIN;
            count_gray <= RST_GRAY;
            wrap       <= 1'b0;
        end else begin
            count_bin  <= bin_nxt;
            count_gray <= gray_nxt;
            wrap       <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb_gray_updown_counter: scoreboard bench for gray_updown_counter.
// 4-bit group: a (wrap, RST 0), b (saturate, RST 0), c (wrap, RST 5) share inputs.
// 6-bit group: d (wrap, RST 0), e (saturate, RST 3) share random inputs.
module tb_gray_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit group
    logic       srst4 = 1'b1, en4 = 1'b0, up4 = 1'b1, load4 = 1'b0;
    logic [3:0] lg4 = '0;
    logic [3:0] a_gray, a_bin, b_gray, b_bin, c_gray, c_bin;
    logic       a_wrap, b_wrap, c_wrap;

    // 6-bit group
    logic       srst6 = 1'b1, en6 = 1'b0, up6 = 1'b1, load6 = 1'b0;
    logic [5:0] lg6 = '0;
    logic [5:0] d_gray, d_bin, e_gray, e_bin;
    logic       d_wrap, e_wrap;

    gray_updown_counter #(.N(4), .SATURATE(1'b0), .RST_VAL(0)) u_a (
        .clk(clk), .srst(srst4), .en(en4), .up_dn(up4), .load(load4), .load_gray(lg4),
        .count_gray(a_gray), .count_bin(a_bin), .wrap(a_wrap));
    gray_updown_counter #(.N(4), .SATURATE(1'b1), .RST_VAL(0)) u_b (
        .clk(clk), .srst(srst4), .en(en4), .up_dn(up4), .load(load4), .load_gray(lg4),
        .count_gray(b_gray), .count_bin(b_bin), .wrap(b_wrap));
    gray_updown_counter #(.N(4), .SATURATE(1'b0), .RST_VAL(5)) u_c (
        .clk(clk), .srst(srst4), .en(en4), .up_dn(up4), .load(load4), .load_gray(lg4),
        .count_gray(c_gray), .count_bin(c_bin), .wrap(c_wrap));
    gray_updown_counter #(.N(6), .SATURATE(1'b0), .RST_VAL(0)) u_d (
        .clk(clk), .srst(srst6), .en(en6), .up_dn(up6), .load(load6), .load_gray(lg6),
        .count_gray(d_gray), .count_bin(d_bin), .wrap(d_wrap));
    gray_updown_counter #(.N(6), .SATURATE(1'b1), .RST_VAL(3)) u_e (
        .clk(clk), .srst(srst6), .en(en6), .up_dn(up6), .load(load6), .load_gray(lg6),
        .count_gray(e_gray), .count_bin(e_bin), .wrap(e_wrap));

    int errors = 0;
    int checks = 0;

    typedef struct { int a; int b; int c; bit wa; bit wb; bit wc; } exp4_t;
    typedef struct { int d; int e; bit wd; bit we; bit step; } exp6_t;
    exp4_t q4[$];
    exp6_t q6[$];
    int ma = 0, mb = 0, mc = 0, md = 0, me = 0;

    // Reference: find the binary value whose Gray code matches, by search
    function automatic int gray_to_bin(input int g, input int n);
        for (int v = 0; v < (1 << n); v++) if ((v ^ (v >> 1)) == g) return v;
        return -1;
    endfunction

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int mstep(input int cur, input int n, input bit sat, input int rv,
                                 input bit s, input bit l, input int lg, input bit e,
                                 input bit u, output bit w);
        int top;
        top = (1 << n) - 1;
        w = 1'b0;
        if (s) return rv;
        if (l) return gray_to_bin(lg, n);
        if (!e) return cur;
        if (u) begin
            if (cur != top) return cur + 1;
            if (sat) return cur;
            w = 1'b1;
            return 0;
        end
        if (cur != 0) return cur - 1;
        if (sat) return cur;
        w = 1'b1;
        return top;
    endfunction

    // Drive one cycle on the 4-bit group, push the expectation, sample at +1
    task automatic cyc4(input bit s, input bit l, input int lg, input bit e, input bit u);
        exp4_t x;
        srst4 = s; load4 = l; lg4 = 4'(lg); en4 = e; up4 = u;
        ma = mstep(ma, 4, 1'b0, 0, s, l, lg, e, u, x.wa);
        mb = mstep(mb, 4, 1'b1, 0, s, l, lg, e, u, x.wb);
        mc = mstep(mc, 4, 1'b0, 5, s, l, lg, e, u, x.wc);
        x.a = ma; x.b = mb; x.c = mc;
        q4.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp4_t x;
        for (int i = 0; i < 2; i++) begin
            cyc4(1, 0, 0, 0, 1);
            x = q4.pop_front();
            checks++;
            if ({a_bin, a_gray, a_wrap} !== {4'(x.a), 4'(gray_of(x.a)), x.wa} ||
                {a_bin, a_gray, a_wrap} !== 9'b0000_0000_0) begin
                errors++;
                $display("FAIL reset_a: got bin=%h gray=%b wrap=%b want 0 0000 0", a_bin, a_gray, a_wrap);
            end
            checks++;
            if ({c_bin, c_gray, c_wrap} !== 9'b0101_0111_0) begin
                errors++;
                $display("FAIL reset_c: got bin=%h gray=%b wrap=%b want 5 0111 0", c_bin, c_gray, c_wrap);
            end
        end
    endtask

    task automatic test_up_wrap();
        exp4_t x;
        logic [3:0] seq [16];
        seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        for (int i = 0; i < 16; i++) begin
            cyc4(0, 0, 0, 1, 1);
            x = q4.pop_front();
            checks++;
            if (a_gray !== seq[i] || a_bin !== 4'(x.a) || a_wrap !== (i == 15)) begin
                errors++;
                $display("FAIL up_seq[%0d]: got gray=%b bin=%h wrap=%b want gray=%b bin=%h wrap=%b",
                         i, a_gray, a_bin, a_wrap, seq[i], 4'(x.a), (i == 15));
            end
        end
    endtask

    task automatic test_down_wrap();
        exp4_t x;
        cyc4(0, 0, 0, 1, 0);
        x = q4.pop_front();
        checks++;
        if ({a_bin, a_gray, a_wrap} !== {4'd15, 4'b1000, 1'b1} || a_bin !== 4'(x.a)) begin
            errors++;
            $display("FAIL down_wrap: got bin=%h gray=%b wrap=%b want f 1000 1", a_bin, a_gray, a_wrap);
        end
        cyc4(0, 0, 0, 1, 0);
        x = q4.pop_front();
        checks++;
        if ({a_bin, a_gray, a_wrap} !== {4'd14, 4'b1001, 1'b0} || a_wrap !== x.wa) begin
            errors++;
            $display("FAIL down_next: got bin=%h gray=%b wrap=%b want e 1001 0", a_bin, a_gray, a_wrap);
        end
    endtask

    task automatic test_saturate();
        exp4_t x;
        cyc4(0, 1, gray_of(14), 0, 1);
        x = q4.pop_front();
        for (int i = 0; i < 3; i++) begin
            cyc4(0, 0, 0, 1, 1);
            x = q4.pop_front();
            checks++;
            if (b_bin !== 4'd15 || b_gray !== 4'b1000 || b_wrap !== 1'b0 || a_bin !== 4'(x.a) ||
                a_wrap !== x.wa) begin
                errors++;
                $display("FAIL sat_up[%0d]: got b=%h/%b/%b a=%h/%b want b=f/1000/0 a=%h/%b",
                         i, b_bin, b_gray, b_wrap, a_bin, a_wrap, 4'(x.a), x.wa);
            end
        end
        cyc4(0, 1, gray_of(1), 0, 0);
        x = q4.pop_front();
        for (int i = 0; i < 3; i++) begin
            cyc4(0, 0, 0, 1, 0);
            x = q4.pop_front();
            checks++;
            if (b_bin !== 4'd0 || b_gray !== 4'b0000 || b_wrap !== 1'b0 || a_bin !== 4'(x.a) ||
                a_wrap !== x.wa) begin
                errors++;
                $display("FAIL sat_dn[%0d]: got b=%h/%b/%b a=%h/%b want b=0/0000/0 a=%h/%b",
                         i, b_bin, b_gray, b_wrap, a_bin, a_wrap, 4'(x.a), x.wa);
            end
        end
    endtask

    task automatic test_load();
        exp4_t x;
        cyc4(0, 1, 'b1101, 1, 1);
        x = q4.pop_front();
        checks++;
        if ({a_bin, a_gray, a_wrap} !== {4'd9, 4'b1101, 1'b0} || a_bin !== 4'(x.a)) begin
            errors++;
            $display("FAIL load: got bin=%h gray=%b wrap=%b want 9 1101 0", a_bin, a_gray, a_wrap);
        end
        cyc4(0, 0, 0, 1, 1);
        x = q4.pop_front();
        checks++;
        if ({a_bin, a_gray} !== {4'd10, 4'b1111}) begin
            errors++;
            $display("FAIL load_step: got bin=%h gray=%b want a 1111", a_bin, a_gray);
        end
        // load from the terminal value: a load never pulses wrap
        cyc4(0, 1, 'b1000, 1, 1);
        x = q4.pop_front();
        cyc4(0, 1, 'b0000, 1, 1);
        x = q4.pop_front();
        checks++;
        if ({a_bin, a_wrap} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL load_nowrap: got bin=%h wrap=%b want 0 0", a_bin, a_wrap);
        end
    endtask

    task automatic test_back_to_back();
        exp4_t x;
        bit dirs [8];
        dirs = '{1, 0, 0, 1, 1, 1, 0, 1};
        for (int i = 0; i < 8; i++) begin
            cyc4(0, 0, 0, (i != 5), dirs[i]);
            x = q4.pop_front();
            checks++;
            if (a_bin !== 4'(x.a) || a_gray !== 4'(gray_of(x.a)) || a_wrap !== x.wa ||
                b_bin !== 4'(x.b) || b_wrap !== x.wb) begin
                errors++;
                $display("FAIL b2b[%0d]: got a=%h/%b/%b b=%h/%b want a=%h/%b b=%h/%b", i, a_bin,
                         a_gray, a_wrap, b_bin, b_wrap, 4'(x.a), x.wa, 4'(x.b), x.wb);
            end
        end
    endtask

    task automatic test_srst_priority();
        exp4_t x;
        cyc4(1, 1, 'b1111, 1, 1);
        x = q4.pop_front();
        checks++;
        if ({c_bin, c_gray, c_wrap} !== {4'd5, 4'b0111, 1'b0} || c_bin !== 4'(x.c) ||
            a_bin !== 4'd0) begin
            errors++;
            $display("FAIL srst_prio: got c=%h/%b/%b a=%h want c=5/0111/0 a=0", c_bin, c_gray,
                     c_wrap, a_bin);
        end
    endtask

    task automatic test_random();
        exp6_t x;
        logic [5:0] pd, pe;
        bit s, l, e, u;
        int lg;
        for (int i = 0; i < 10000; i++) begin
            s  = (i < 2) || ($urandom_range(0, 199) == 0);
            l  = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = ($urandom_range(0, 1) == 1);
            lg = int'($urandom_range(0, 63));
            srst6 = s; load6 = l; en6 = e; up6 = u; lg6 = 6'(lg);
            pd = d_gray; pe = e_gray;
            md = mstep(md, 6, 1'b0, 0, s, l, lg, e, u, x.wd);
            me = mstep(me, 6, 1'b1, 3, s, l, lg, e, u, x.we);
            x.d = md; x.e = me; x.step = !s && !l && e;
            q6.push_back(x);
            @(posedge clk);
            #1;
            x = q6.pop_front();
            checks++;
            if (d_bin !== 6'(x.d) || d_wrap !== x.wd || e_bin !== 6'(x.e) || e_wrap !== x.we) begin
                errors++;
                $display("FAIL rnd_model[%0d]: got d=%h/%b e=%h/%b want d=%h/%b e=%h/%b", i,
                         d_bin, d_wrap, e_bin, e_wrap, 6'(x.d), x.wd, 6'(x.e), x.we);
            end
            checks++;
            if (d_gray !== (d_bin ^ (d_bin >> 1)) || e_gray !== (e_bin ^ (e_bin >> 1))) begin
                errors++;
                $display("FAIL rnd_gray[%0d]: got d=%b/%h e=%b/%h want gray=bin^(bin>>1)", i,
                         d_gray, d_bin, e_gray, e_bin);
            end
            if (x.step && i >= 2) begin
                checks++;
                if ($countones(pd ^ d_gray) != 1) begin
                    errors++;
                    $display("FAIL rnd_ham_d[%0d]: got %b->%b want 1 bit changed", i, pd, d_gray);
                end
                if (pe !== e_gray) begin
                    checks++;
                    if ($countones(pe ^ e_gray) != 1) begin
                        errors++;
                        $display("FAIL rnd_ham_e[%0d]: got %b->%b want 1 bit changed", i, pe, e_gray);
                    end
                end
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_load();
        test_back_to_back();
        test_srst_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
